// File: rtl/ap_pass_ctrl.sv
// -----------------------------------------------------------------------------
// ap_pass_ctrl
//
// Pass controller for an associative-processor CAM. One command runs one
// "pass": the key/mask are presented to the CAM, the combinational tag
// vector the CAM returns is captured (replacing or OR-accumulating into the
// held tags), and optionally a single parallel-write cycle writes cmd_wdata
// into every tagged cell. A one-cycle done pulse closes the pass.
//
// Pass timeline (accept edge = edge at end of the IDLE cycle):
//   write pass  : IDLE -> CMP -> WR -> RSP (done 3 cycles after accept)
//   search pass : IDLE -> CMP -> RSP       (done 2 cycles after accept)
//
// Optional build macro:
//   AP_TAG_COUNT_EN - adds output tag_count, the registered popcount of
//                     tag_reg, refreshed on the edge entering RSP.
//
// Ports:
//   CLK100MHZ         in   clock, all state updates on the rising edge
//   rst               in   synchronous reset, active low
//   cmd_valid         in   pass command offered
//   cmd_ready         out  controller accepts a command (IDLE only)
//   cmd_key           in   compare key
//   cmd_mask          in   compare mask
//   cmd_wdata         in   data for the parallel write
//   cmd_write         in   1 = compare then parallel write, 0 = search only
//   cmd_acc           in   1 = OR new tags into held tags, 0 = replace
//   tags              in   combinational match vector from the CAM
//   cam_key           out  key driven to the CAM
//   cam_mask          out  mask driven to the CAM
//   cam_dina          out  write data driven to the CAM
//   cam_mode          out  1 = tag-guided parallel write (WR only)
//   cell_wea_ctrl_ap  out  per-cell write enables (tag_reg in WR, else 0)
//   tag_reg           out  held tag vector
//   match_any         out  OR-reduction of tag_reg
//   done              out  one-cycle pass-complete pulse
//   tag_count         out  popcount of tag_reg (AP_TAG_COUNT_EN only)
// -----------------------------------------------------------------------------
module ap_pass_ctrl #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WORD_SIZE-1:0]  cmd_key,
    input  logic [WORD_SIZE-1:0]  cmd_mask,
    input  logic [WORD_SIZE-1:0]  cmd_wdata,
    input  logic                  cmd_write,
    input  logic                  cmd_acc,
    input  logic [CELL_QUANT-1:0] tags,
    output logic [WORD_SIZE-1:0]  cam_key,
    output logic [WORD_SIZE-1:0]  cam_mask,
    output logic [WORD_SIZE-1:0]  cam_dina,
    output logic                  cam_mode,
    output logic [CELL_QUANT-1:0] cell_wea_ctrl_ap,
    output logic [CELL_QUANT-1:0] tag_reg,
    output logic                  match_any,
    output logic                  done
`ifdef AP_TAG_COUNT_EN
    ,
    output logic [$clog2(CELL_QUANT+1)-1:0] tag_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Registered command fields; key/mask double as the CAM drive.
    logic [WORD_SIZE-1:0]  key_q,   key_d;
    logic [WORD_SIZE-1:0]  mask_q,  mask_d;
    logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  acc_q,   acc_d;

    // CAM write data holds its last value outside WR, so it is its own flop.
    logic [WORD_SIZE-1:0]  dina_q,  dina_d;

    logic [CELL_QUANT-1:0] tag_reg_q, tag_reg_d;

    logic accept;

`ifdef AP_TAG_COUNT_EN
    localparam int CNT_W = $clog2(CELL_QUANT + 1);
    logic [CNT_W-1:0] tag_count_q, tag_count_d;
`endif

    assign accept = cmd_valid && (state_q == IDLE);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of order.
    always_ff @(posedge CLK100MHZ) begin
        if (!rst) begin
            state_q   <= IDLE;
            key_q     <= '0;
            mask_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            acc_q     <= 1'b0;
            dina_q    <= '0;
            tag_reg_q <= '0;
`ifdef AP_TAG_COUNT_EN
            tag_count_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            mask_q    <= mask_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            acc_q     <= acc_d;
            dina_q    <= dina_d;
            tag_reg_q <= tag_reg_d;
`ifdef AP_TAG_COUNT_EN
            tag_count_q <= tag_count_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: each combinational block assigns a default to every output first,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)  state_d = CMP;
            CMP:  state_d = write_q ? WR : RSP;
            WR:   state_d = RSP;
            RSP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        key_d     = key_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        acc_d     = acc_q;
        dina_d    = dina_q;
        tag_reg_d = tag_reg_q;

        if (accept) begin
            key_d   = cmd_key;
            mask_d  = cmd_mask;
            wdata_d = cmd_wdata;
            write_d = cmd_write;
            acc_d   = cmd_acc;
        end

        // The CAM answers combinationally to the key/mask presented in CMP,
        // so the tag vector is captured on the edge leaving CMP.
        if (state_q == CMP) begin
            tag_reg_d = acc_q ? (tag_reg_q | tags) : tags;
            // Load write data on the edge entering WR so it is stable for the
            // whole write cycle and then simply held afterwards.
            if (write_q) begin
                dina_d = wdata_q;
            end
        end
    end

`ifdef AP_TAG_COUNT_EN
    // Popcount of the tag vector as it will be in RSP. On the CMP->RSP path
    // tag_reg is updated on that same edge, hence tag_reg_d, not tag_reg_q.
    always_comb begin
        tag_count_d = tag_count_q;
        if ((state_d == RSP) && (state_q != RSP)) begin
            tag_count_d = '0;
            for (int i = 0; i < CELL_QUANT; i++) begin
                tag_count_d = tag_count_d + CNT_W'(tag_reg_d[i]);
            end
        end
    end

    assign tag_count = tag_count_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready        = (state_q == IDLE);
        cam_mode         = (state_q == WR);
        cell_wea_ctrl_ap = (state_q == WR) ? tag_reg_q : '0;
        done             = (state_q == RSP);
        cam_key          = key_q;
        cam_mask         = mask_q;
        cam_dina         = dina_q;
        tag_reg          = tag_reg_q;
        match_any        = |tag_reg_q;
    end

endmodule

// File: tb/tb_ap_pass_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ap_pass_ctrl
//
// Scoreboard bench for ap_pass_ctrl (WORD_SIZE=8, CELL_QUANT=8). The stimulus
// process issues directed commands and pushes the expected done response and
// expected write-cycle contents into queues; a negedge monitor pops and
// compares whenever the DUT shows done or cam_mode.
// -----------------------------------------------------------------------------
module tb_ap_pass_ctrl;

    localparam int W = 8;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_key, cmd_mask, cmd_wdata;
    logic         cmd_write, cmd_acc;
    logic [N-1:0] tags;
    logic [W-1:0] cam_key, cam_mask, cam_dina;
    logic         cam_mode;
    logic [N-1:0] cell_wea_ctrl_ap;
    logic [N-1:0] tag_reg;
    logic         match_any;
    logic         done;
`ifdef AP_TAG_COUNT_EN
    logic [$clog2(N+1)-1:0] tag_count;
`endif

    always #5 clk = ~clk;

    ap_pass_ctrl #(.WORD_SIZE(W), .CELL_QUANT(N)) dut (
        .CLK100MHZ        (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_key          (cmd_key),
        .cmd_mask         (cmd_mask),
        .cmd_wdata        (cmd_wdata),
        .cmd_write        (cmd_write),
        .cmd_acc          (cmd_acc),
        .tags             (tags),
        .cam_key          (cam_key),
        .cam_mask         (cam_mask),
        .cam_dina         (cam_dina),
        .cam_mode         (cam_mode),
        .cell_wea_ctrl_ap (cell_wea_ctrl_ap),
        .tag_reg          (tag_reg),
        .match_any        (match_any),
        .done             (done)
`ifdef AP_TAG_COUNT_EN
        ,
        .tag_count        (tag_count)
`endif
    );

    typedef struct {
        int unsigned  cyc;
        logic [N-1:0] tag;
        logic         m_any;
        logic [W-1:0] key;
        logic [W-1:0] mask;
        int           cnt;
    } done_t;

    typedef struct {
        logic [N-1:0] wea;
        logic [W-1:0] dina;
    } wr_t;

    done_t done_q[$];
    wr_t   wr_q[$];

    int unsigned  cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    bit           mon_en = 1'b0;
    logic [N-1:0] model_tag = '0;
    int unsigned  last_accept = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents done or a write cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    done_t e;
                    e = done_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("tag_reg", 32'(tag_reg), 32'(e.tag));
                    check("match_any", 32'(match_any), 32'(e.m_any));
                    check("cam_key", 32'(cam_key), 32'(e.key));
                    check("cam_mask", 32'(cam_mask), 32'(e.mask));
`ifdef AP_TAG_COUNT_EN
                    check("tag_count", 32'(tag_count), 32'(e.cnt));
`endif
                end
            end
            if (cam_mode === 1'b1) begin
                if (wr_q.size() == 0) begin
                    check("cam_mode_unexpected", 32'(cam_mode), 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("wr_wea", 32'(cell_wea_ctrl_ap), 32'(w.wea));
                    check("wr_dina", 32'(cam_dina), 32'(w.dina));
                end
            end else begin
                check("wea_outside_wr", 32'(cell_wea_ctrl_ap), 32'd0);
            end
        end
    end

    // Offer a command (called at a negedge) and push its expected responses.
    // Returns at the negedge of the CMP cycle.
    task automatic send_cmd(input logic [W-1:0] k, input logic [W-1:0] m,
                            input logic [W-1:0] wd, input logic wr, input logic ac,
                            input logic [N-1:0] tg, input bit exp_done, input bit hold);
        int    waited = 0;
        done_t d;
        wr_t   w;
        cmd_valid = 1'b1;
        cmd_key   = k;
        cmd_mask  = m;
        cmd_wdata = wd;
        cmd_write = wr;
        cmd_acc   = ac;
        tags      = tg;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        last_accept = cyc;
        model_tag = ac ? (model_tag | tg) : tg;
        if (wr) begin
            w.wea  = model_tag;
            w.dina = wd;
            wr_q.push_back(w);
        end
        if (exp_done) begin
            d.cyc   = cyc + (wr ? 3 : 2);
            d.tag   = model_tag;
            d.m_any = |model_tag;
            d.key   = k;
            d.mask  = m;
            d.cnt   = $countones(model_tag);
            done_q.push_back(d);
        end
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    int unsigned a_acc;

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_key   = '0;
        cmd_mask  = '0;
        cmd_wdata = '0;
        cmd_write = 1'b0;
        cmd_acc   = 1'b0;
        tags      = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cam_mode", 32'(cam_mode), 32'd0);
        check("rst_wea", 32'(cell_wea_ctrl_ap), 32'd0);
        check("rst_tag_reg", 32'(tag_reg), 32'd0);
        check("rst_match_any", 32'(match_any), 32'd0);
        check("rst_cam_key", 32'(cam_key), 32'd0);
        check("rst_cam_dina", 32'(cam_dina), 32'd0);
        rst    = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Write pass: tags 0x24 written with 0xA5
        send_cmd(8'h0F, 8'hFF, 8'hA5, 1'b1, 1'b0, 8'h24, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("dina_held", 32'(cam_dina), 32'hA5);

        // Search then accumulate: 0x81 then 0x81|0x10
        send_cmd(8'h33, 8'hF0, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        send_cmd(8'h44, 8'h0F, 8'h00, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("tag_held", 32'(tag_reg), 32'h91);

        // Write pass with no tags: WR still entered, nothing enabled
        send_cmd(8'h55, 8'hFF, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (5) @(negedge clk);

        // Back-to-back with cmd_valid held high
        send_cmd(8'h11, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
        a_acc = last_accept;
        check("ready_cmp", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("ready_wr", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("ready_rsp", 32'(cmd_ready), 32'd0);
        send_cmd(8'h22, 8'h0F, 8'h00, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0);
        check("b2b_accept_cycle", last_accept, a_acc + 4);
        repeat (4) @(negedge clk);

        // Reset during WR: WR cycle seen, then everything aborted
        send_cmd(8'h66, 8'hFF, 8'hC3, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_cam_mode", 32'(cam_mode), 32'd0);
        check("abort_wea", 32'(cell_wea_ctrl_ap), 32'd0);
        check("abort_tag_reg", 32'(tag_reg), 32'd0);
        check("abort_match_any", 32'(match_any), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        rst       = 1'b1;
        model_tag = '0;
        repeat (4) @(negedge clk);

        // Reset dominates a simultaneous command accept
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_acc   = 1'b0;
        tags      = 8'hFF;
        rst       = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        check("rstdom_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        check("rstdom_ready2", 32'(cmd_ready), 32'd1);
        check("rstdom_tag_reg", 32'(tag_reg), 32'd0);
        repeat (2) @(negedge clk);

        // Popcount pass: 0xF1 has five bits set
        send_cmd(8'h77, 8'hFF, 8'h00, 1'b0, 1'b0, 8'hF1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
`ifdef AP_TAG_COUNT_EN
        check("tag_count_held", 32'(tag_count), 32'd5);
`endif

        // Drain outstanding expectations with a bounded wait
        for (int i = 0; i < 50 && (done_q.size() != 0 || wr_q.size() != 0); i++) begin
            @(negedge clk);
        end
        check("done_queue_drained", 32'(done_q.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
